tile_reader: RTL and testbench

- Read-side scan engine for the systolic array.
- On `start`, walks a WIDTH x HEIGHT tile in a synchronous-read buffer, row-major: pixel fastest, slice slowest.
- Issues addresses and absorbs the buffer's 1-cycle read latency.
- Presents the data as a valid/ready stream with pixel/slice tags and start-of-frame, end-of-line and end-of-frame markers, feeding the array's edge or the result-drain path.

---
 rtl/tile_pkg.sv | 24 ++
 rtl/tile_skid_fifo.sv | 76 +++++++
 rtl/tile_reader.sv | 198 +++++++++++++++++++
 tb/tb_tile_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile reader and its skid FIFO.
package tile_pkg;

  // Scan engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Frame markers carried with every beat. The parameter-dependent beat
  // (data, pixel, slice, flags) is assembled from this inside the reader.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } beat_flags_t;

  // clog2 that never returns 0, so a 1-wide dimension still gets a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_skid_fifo.sv
// Two-entry valid/ready skid FIFO. The head entry drives the output and
// stays stable until popped. A push while full without a pop is dropped,
// so producers gate pushes with count_o.
module tile_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign count_o     = count_q;

  // Slot update: head always holds the oldest entry, tail the younger one.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (count_q)
      2'd0: begin
        if (in_valid_i) begin
          head_d  = in_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid_i && pop) begin
          head_d = in_data_i;
        end else if (in_valid_i) begin
          tail_d  = in_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          if (in_valid_i) tail_d = in_data_i;
          else            count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: storage is reset too, because the head drives outputs that must read 0 in reset.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tile_reader.sv
// Read-side scan engine: walks a WIDTH x HEIGHT tile in a synchronous-read
// buffer and streams it out with pixel/slice tags and frame markers.
// Optional TILE_READER_TRANSPOSE_EN adds a 'transpose' input selecting a
// column-major scan for the frame.
module tile_reader
  import tile_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int HEIGHT = 32,
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = clog2_min1(WIDTH * HEIGHT),
  localparam int PW     = clog2_min1(WIDTH),
  localparam int SW     = clog2_min1(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef TILE_READER_TRANSPOSE_EN
  input  logic              transpose,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [PW-1:0]     m_pixel,
  output logic [SW-1:0]     m_slice,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam logic [PW-1:0] PIX_LAST = PW'(WIDTH - 1);
  localparam logic [SW-1:0] SLC_LAST = SW'(HEIGHT - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PW-1:0]     pixel;
    logic [SW-1:0]     slice;
    beat_flags_t       flags;
  } beat_t;

  state_e            state_q, state_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [SW-1:0]     slc_q, slc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              rd_en, accept, last_rd, col_major, pop, credit_ok;
  logic              pend_q;
  logic [PW-1:0]     pix_tag_q;
  logic [SW-1:0]     slc_tag_q;
  beat_flags_t       flags_tag_q, flags_now;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  beat_t             push_beat, head_beat;

`ifdef TILE_READER_TRANSPOSE_EN
  logic tr_q, tr_d;
  assign col_major = tr_q;
`else
  assign col_major = 1'b0;
`endif

  assign accept  = (state_q == IDLE) && start;
  assign last_rd = (pix_q == PIX_LAST) && (slc_q == SLC_LAST);
  assign pop     = fifo_valid && m_ready;
  // Occupancy is counted after this cycle's pop, so a steady stream keeps
  // one read in flight and one beat in the FIFO: one beat per cycle.
  assign credit_ok = ((fifo_count - {1'b0, pop}) + {1'b0, pend_q}) < 2'd2;

  assign flags_now.sof = (pix_q == '0) && (slc_q == '0);
  assign flags_now.eol = col_major ? (slc_q == SLC_LAST) : (pix_q == PIX_LAST);
  assign flags_now.eof = last_rd;

  // FSM next state, read enable and end-of-frame pulse.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        rd_en = credit_ok;
        if (credit_ok && last_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (fifo_count == 2'd1) && !pend_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan position and running address of the next read.
  always_comb begin
    pix_d  = pix_q;
    slc_d  = slc_q;
    addr_d = addr_q;
`ifdef TILE_READER_TRANSPOSE_EN
    tr_d   = accept ? transpose : tr_q;
`endif
    if (accept || (rd_en && last_rd)) begin
      pix_d  = '0;
      slc_d  = '0;
      addr_d = '0;
    end else if (rd_en && col_major) begin
      if (slc_q == SLC_LAST) begin
        slc_d  = '0;
        pix_d  = pix_q + PW'(1);
        addr_d = ADDR_W'(pix_q) + ADDR_W'(1);
      end else begin
        slc_d  = slc_q + SW'(1);
        addr_d = addr_q + ADDR_W'(WIDTH);
      end
    end else if (rd_en) begin
      addr_d = addr_q + ADDR_W'(1);
      if (pix_q == PIX_LAST) begin
        pix_d = '0;
        slc_d = slc_q + SW'(1);
      end else begin
        pix_d = pix_q + PW'(1);
      end
    end
  end

  // Control and scan registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      pix_q   <= '0;
      slc_q   <= '0;
      addr_q  <= '0;
`ifdef TILE_READER_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pix_q   <= pix_d;
      slc_q   <= slc_d;
      addr_q  <= addr_d;
`ifdef TILE_READER_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end

  // Tags travel one cycle alongside the buffer's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pix_tag_q   <= '0;
      slc_tag_q   <= '0;
      flags_tag_q <= '0;
    end else begin
      pend_q <= rd_en;
      if (rd_en) begin
        pix_tag_q   <= pix_q;
        slc_tag_q   <= slc_q;
        flags_tag_q <= flags_now;
      end
    end
  end

  assign push_beat = '{data: mem_rd_data, pixel: pix_tag_q, slice: slc_tag_q, flags: flags_tag_q};

  tile_skid_fifo #(
    .W($bits(beat_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (pend_q),
    .in_data_i   (push_beat),
    .out_valid_o (fifo_valid),
    .out_ready_i (m_ready),
    .out_data_o  (head_beat),
    .count_o     (fifo_count)
  );

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = addr_q;
  assign m_valid     = fifo_valid;
  assign m_data      = head_beat.data;
  assign m_pixel     = head_beat.pixel;
  assign m_slice     = head_beat.slice;
  assign m_sof       = head_beat.flags.sof;
  assign m_eol       = head_beat.flags.eol;
  assign m_eof       = head_beat.flags.eof;

endmodule

// File: tb/tb_tile_reader.sv
// Directed bench for tile_reader: a 4x3 instance (buffer word = address)
// and a 1x1 instance. Transposed frames run when TILE_READER_TRANSPOSE_EN
// is defined.
module tb_tile_reader;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 4x3 instance
  logic        start, busy, done, mem_rd_en, m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data, m_data;
  logic [1:0]  m_pixel, m_slice;
`ifdef TILE_READER_TRANSPOSE_EN
  logic        transpose;
`endif

  // 1x1 instance
  logic        start1, busy1, done1, rd_en1, m_valid1, m_ready1, sof1, eol1, eof1;
  logic [0:0]  rd_addr1, m_pixel1, m_slice1;
  logic [15:0] rd_data1, m_data1;

  tile_reader #(.WIDTH(4), .HEIGHT(3), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef TILE_READER_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_pixel(m_pixel), .m_slice(m_slice), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  tile_reader #(.WIDTH(1), .HEIGHT(1), .DATA_W(16)) u_one (
    .clk(clk), .rst(rst), .start(start1),
`ifdef TILE_READER_TRANSPOSE_EN
    .transpose(1'b0),
`endif
    .busy(busy1), .done(done1), .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1),
    .mem_rd_data(rd_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
    .m_pixel(m_pixel1), .m_slice(m_slice1), .m_sof(sof1), .m_eol(eol1), .m_eof(eof1)
  );

  // Synchronous-read buffers whose word equals its address.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {12'd0, mem_rd_addr};
  always @(posedge clk) if (rd_en1)    rd_data1    <= {15'd0, rd_addr1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One 4x3 frame: tr = column-major, rnd = stalling ready pattern,
  // restarts = extra start pulses at frame cycles 2 and 6.
  task automatic scan_frame(input bit tr, input bit rnd, input bit restarts);
    int          order [12];
    int          k, rd_k, done_cnt, hs_last, done_rel, rel, occ, pend, a;
    bit          held, pop, finished;
    logic [23:0] hold_v, obs_v, exp_v;
    logic [39:0] rdy_pat;
    rdy_pat = 40'b10111001_01101011_00000111_01001101_00000111;
    for (int i = 0; i < 12; i++) order[i] = tr ? ((i % 3) * 4 + i / 3) : i;
    k = 0; rd_k = 0; done_cnt = 0; hs_last = -1; done_rel = 0; occ = 0; pend = 0;
    held = 1'b0; finished = 1'b0; hold_v = '0;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b1; m_ready = 1'b1;
`ifdef TILE_READER_TRANSPOSE_EN
    transpose = tr;
`endif
    #1;
    check("idle_before_start", {busy, m_valid, mem_rd_en}, 3'b000);
    for (int c = 0; c < 300 && !finished; c++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      m_ready = rnd ? rdy_pat[rel % 40] : 1'b1;
      start = restarts && (rel == 2 || rel == 6);
`ifdef TILE_READER_TRANSPOSE_EN
      transpose = ~tr;
`endif
      #1;
      pop   = m_valid && m_ready;
      obs_v = {m_valid, m_data, m_pixel, m_slice, m_sof, m_eol, m_eof};
      check("busy", busy, hs_last < 0);
      check("occupancy_valid", m_valid, occ != 0);
      if (mem_rd_en) begin
        check("credit", (occ - int'(pop) + pend) < 2, 1);
        if (rd_k == 0) check("first_read_cyc", rel, 1);
        if (rd_k < 12) check("rd_addr", mem_rd_addr, order[rd_k]);
        else           check("extra_read", mem_rd_en, 0);
        rd_k++;
      end
      if (held) check("hold_stable", obs_v, hold_v);
      if (pop) begin
        if (k < 12) begin
          a = order[k];
          exp_v = {1'b1, 16'(a), 2'(a % 4), 2'(a / 4), k == 0,
                   tr ? (a / 4 == 2) : (a % 4 == 3), k == 11};
          check($sformatf("beat%0d", k), obs_v, exp_v);
          if (!rnd) check("beat_cyc", rel, 3 + k);
          if (k == 11) hs_last = rel;
        end else begin
          check("extra_beat", m_valid, 0);
        end
        k++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        check("done_cyc", rel, hs_last + 1);
      end
      if (done_cnt > 0 && rel >= done_rel + 3) finished = 1'b1;
      occ  = occ - int'(pop) + pend;
      pend = int'(mem_rd_en);
      held = m_valid && !m_ready;
      hold_v = obs_v;
    end
    check("frame_end", finished, 1);
    check("beats", k, 12);
    check("reads", rd_k, 12);
    check("done_count", done_cnt, 1);
    start = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    bit found, rd_prev;
    rst = 1'b1; start = 1'b0; m_ready = 1'b1; start1 = 1'b0; m_ready1 = 1'b1;
`ifdef TILE_READER_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data,
                            m_pixel, m_slice, m_sof, m_eol, m_eof}, '0);
    check("reset_outputs_1x1", {busy1, done1, rd_en1, rd_addr1, m_valid1, m_data1,
                                m_pixel1, m_slice1, sof1, eol1, eof1}, '0);
    #1 rst = 1'b0;

    // Row-major frames: free-flowing, stalled, and with ignored restarts.
    scan_frame(1'b0, 1'b0, 1'b0);
    scan_frame(1'b0, 1'b1, 1'b0);
    scan_frame(1'b0, 1'b0, 1'b1);

    // Asynchronous reset after beat 5 is accepted, while a read is in flight.
    @(posedge clk); #1;
    start = 1'b1; m_ready = 1'b1;
    #1;
    found = 1'b0; rd_prev = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (m_valid && m_ready && m_data == 16'd5) begin
        found   = 1'b1;
        rd_prev = mem_rd_en;
      end
    end
    check("rst_beat5_reached", found, 1);
    check("rst_read_in_flight", rd_prev, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst_outputs_zero", {busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data,
                               m_pixel, m_slice, m_sof, m_eol, m_eof}, '0);
    @(posedge clk); #1;
    check("rst_held", {busy, done, m_valid}, 3'b000);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      check("post_rst_quiet", {busy, done, mem_rd_en, m_valid}, 4'b0000);
    end
    scan_frame(1'b0, 1'b0, 1'b0);

    // 1x1 tile: one beat carrying sof, eol and eof.
    @(posedge clk); #1;
    start1 = 1'b1;
    #1;
    check("one_idle", busy1, 0);
    @(posedge clk); #1;
    start1 = 1'b0;
    #1;
    check("one_read", {busy1, rd_en1, rd_addr1, m_valid1}, 4'b1100);
    @(posedge clk); #2;
    check("one_wait", {busy1, rd_en1, m_valid1}, 3'b100);
    @(posedge clk); #2;
    check("one_beat", {busy1, m_valid1, m_data1, m_pixel1, m_slice1, sof1, eol1, eof1},
          {1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    @(posedge clk); #2;
    check("one_done", {done1, busy1, m_valid1}, 3'b100);
    @(posedge clk); #2;
    check("one_done_pulse", {done1, busy1}, 2'b00);

`ifdef TILE_READER_TRANSPOSE_EN
    // Column-major frames; transpose is flipped after start and must not matter.
    scan_frame(1'b1, 1'b0, 1'b0);
    scan_frame(1'b1, 1'b1, 1'b0);
    scan_frame(1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
